frame_scanout: RTL and testbench
================================

# frame_scanout

Streams a complete frame out of the game's pixel store in raster order. It sits between the `GameBox` frame storage (read port) and the display-side consumer. After a `frame_start` pulse it issues linear reads, absorbs the one-cycle read latency in a 2-entry buffer, and presents pixels on a valid/ready stream tagged with start-of-frame, end-of-line and end-of-frame markers.

## Interface

Parameters:
- `SCR_W`, 400: pixels per line.
- `SCR_H`, 700: lines per frame.
- `PIX_W`, 24: pixel width, packed as r[23:16], g[15:8], b[7:0].
- `ADDR_W`, 19: read address width; must satisfy 2^ADDR_W ≥ SCR_W*SCR_H.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; low forces every register to its reset value.
- `frame_start` in 1: one-cycle request to scan a frame; honoured only in IDLE.
- `rd_en` out 1: read strobe to the pixel store.
- `rd_addr` out ADDR_W: read address, row-major, y*SCR_W+x.
- `rd_data` in PIX_W: read data, valid exactly one cycle after `rd_en`.
- `pix_data` out PIX_W: output pixel.
- `pix_valid` out 1: `pix_data` and the tags are valid.
- `pix_ready` in 1: consumer accepts; transfer = `pix_valid & pix_ready`.
- `pix_sof` out 1: tag for pixel (0,0).
- `pix_eol` out 1: tag for x == SCR_W-1.
- `pix_eof` out 1: tag for the last pixel of the frame.
- `busy` out 1: high from the cycle after an accepted `frame_start` through `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last transfer.

## Operation

- States:
  - IDLE: entered on reset.
  - IDLE→RUN: `frame_start` sampled high; read address counter cleared and output x/y counters cleared.
  - RUN→DRAIN: the read for address SCR_W*SCR_H-1 has been issued.
  - DRAIN→DONE: the transfer tagged `pix_eof` completes.
  - DONE→IDLE: after one cycle; `frame_done`=1 during DONE.
- Occupancy is occ = buffer count + in-flight read (0/1).
  - `rd_en` = 1 in RUN when (occ - pop) < 2, where pop is the transfer in the current cycle.
  - `rd_en` is combinational from registered state and `pix_ready`.
  - `rd_addr` increments by 1 per issued read.
- `rd_data` is written into the 2-entry FIFO at the end of its valid cycle.
- `pix_valid` = FIFO non-empty. `pix_data` is the FIFO head.
- Tags come from output-side counters (out_x, out_y), not from the read address:
  - out_x advances per transfer and wraps at SCR_W-1, which increments out_y.
  - `pix_sof` = (out_x==0 & out_y==0).
  - `pix_eol` = (out_x==SCR_W-1).
  - `pix_eof` = `pix_eol` & (out_y==SCR_H-1).
- `frame_start` in RUN, DRAIN or DONE is ignored and not queued.
- Stream rules:
  - While `pix_valid` & !`pix_ready`, `pix_data`, `pix_valid` and the tags hold stable.
  - No pixel is dropped or duplicated.
- Reset mid-frame: the FIFO is emptied, the in-flight read is discarded (the next-cycle `rd_data` is ignored), and all counters return to 0.
- Reset values:
  - `rd_en`, `rd_addr`, `pix_data`, `pix_valid`, tags, `busy`, `frame_done`: all 0.
  - State: IDLE.

## Timing

- `frame_start` high in cycle N (IDLE):
  - `busy`=1 from N+1.
  - `rd_en`=1 with `rd_addr`=0 in N+1.
  - `rd_data` captured at end of N+2.
  - First `pix_valid` in N+3.
- With `pix_ready` held 1: one read and one transfer per cycle, no bubbles.
  - Last transfer in N+2+SCR_W*SCR_H.
  - `frame_done` in the following cycle.
  - `busy` falls the cycle after `frame_done`.
- With `pix_ready` held 0: exactly 2 reads are issued, then `rd_en` stays 0 until a transfer.
- After a stall, a transfer in cycle M permits `rd_en` in M; the refilled entry becomes visible in M+2. Back-to-back throughput resumes without loss.
- Address counter width: no wrap within a frame; it is cleared on frame start.

## Test plan

Use SCR_W=4, SCR_H=3, and a store model returning rd_data = 0x100000 + addr.

- Free-running frame, `pix_ready`=1, `frame_start` at cycle 5 →
  - pixels 0x100000..0x10000B on cycles 8..19 contiguous.
  - `pix_sof` on 0x100000.
  - `pix_eol` on 0x100003/0x100007/0x10000B.
  - `pix_eof` on 0x10000B.
  - `frame_done` at cycle 20.
- Random `pix_ready` (50%) → same 12 values in order, none duplicated. Output stable while stalled. occ never exceeds 2.
- `pix_ready`=0 for 10 cycles after `frame_start` → exactly 2 `rd_en` pulses (addr 0,1). After release, the full frame completes correctly.
- `frame_start` pulsed during RUN and DONE → ignored, one frame only. A `frame_start` after `busy` falls produces a second identical frame.
- `reset` low for 1 cycle after pixel 5 is accepted → all outputs 0 immediately and state IDLE. A stale `rd_data` is not emitted. A new `frame_start` restarts at addr 0 with `pix_sof`.
- Default parameters, `pix_ready`=1 → 280000 transfers. The last one carries `rd_addr`-sourced value 279999 and `pix_eof`, and `frame_done` follows 1 cycle later.

Source files
------------

// File: rtl/frame_scanout.sv
// frame_scanout
// Streams one full frame out of the pixel store in raster order. A frame_start
// pulse in IDLE starts linear reads (row-major address y*SCR_W+x). Read data
// arrives one cycle after rd_en and lands in a 2-entry FIFO, which feeds a
// valid/ready pixel stream tagged with start-of-frame, end-of-line and
// end-of-frame markers.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   frame_start  one-cycle scan request, honoured only in IDLE
//   rd_en        read strobe to the pixel store
//   rd_addr      read address
//   rd_data      read data, valid one cycle after rd_en
//   pix_data     FIFO head pixel (zero while not valid)
//   pix_valid    FIFO non-empty
//   pix_ready    consumer accepts; transfer = pix_valid & pix_ready
//   pix_sof      tag: pixel (0,0)
//   pix_eol      tag: last pixel of a line
//   pix_eof      tag: last pixel of the frame
//   busy         high from the cycle after an accepted frame_start through frame_done
//   frame_done   one-cycle pulse after the last transfer
module frame_scanout #(
    parameter int SCR_W  = 400,
    parameter int SCR_H  = 700,
    parameter int PIX_W  = 24,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (SCR_W > 1) ? $clog2(SCR_W) : 1;
    localparam int YW = (SCR_H > 1) ? $clog2(SCR_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCR_W * SCR_H - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(SCR_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(SCR_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [XW-1:0]       out_x_q, out_x_d;
    logic [YW-1:0]       out_y_q, out_y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                inflight_q;
    logic [PIX_W-1:0]    fifo_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;

    logic                pop_s;
    logic                rd_en_s;
    logic [1:0]          occ_s;
    logic                at_eol_s;
    logic                at_last_line_s;

    // Occupancy counts the buffered entries plus the read still in flight;
    // a read may issue whenever this cycle's pop leaves room for it.
    assign pix_valid      = (count_q != 2'd0);
    assign pop_s          = pix_valid & pix_ready;
    assign occ_s          = count_q + {1'b0, inflight_q};
    assign rd_en_s        = (state_q == ST_RUN) && ((occ_s - {1'b0, pop_s}) < 2'd2);
    assign at_eol_s       = (out_x_q == X_LAST);
    assign at_last_line_s = (out_y_q == Y_LAST);

    assign rd_en      = rd_en_s;
    assign rd_addr    = rd_addr_q;
    assign pix_data   = pix_valid ? fifo_q[rd_ptr_q] : {PIX_W{1'b0}};
    // Tags are gated by pix_valid so they read 0 whenever no pixel is offered.
    assign pix_sof    = pix_valid & (out_x_q == {XW{1'b0}}) & (out_y_q == {YW{1'b0}});
    assign pix_eol    = pix_valid & at_eol_s;
    assign pix_eof    = pix_valid & at_eol_s & at_last_line_s;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Next-state logic for the sequencer, read address and output raster counters.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (pop_s) begin
            if (at_eol_s) begin
                out_x_d = {XW{1'b0}};
                out_y_d = at_last_line_s ? {YW{1'b0}} : (out_y_q + YW'(1'b1));
            end else begin
                out_x_d = out_x_q + XW'(1'b1);
            end
        end else begin
            out_x_d = out_x_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_RUN;
                    rd_addr_d = {ADDR_W{1'b0}};
                    out_x_d   = {XW{1'b0}};
                    out_y_d   = {YW{1'b0}};
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_en_s) begin
                    rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d   = (rd_addr_q == LAST_ADDR) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && at_eol_s && at_last_line_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= {ADDR_W{1'b0}};
            out_x_q   <= {XW{1'b0}};
            out_y_q   <= {YW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Read-latency tracking and 2-entry FIFO; reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            fifo_q[0]  <= {PIX_W{1'b0}};
            fifo_q[1]  <= {PIX_W{1'b0}};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= rd_en_s;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout with a 4x3 frame. The pixel store
// returns 0x100000 + addr one cycle after rd_en. The reference model is the
// raster sequence itself: pixel i carries 0x100000+i, sof at i==0, eol when
// i%W==W-1 and eof at i==W*H-1.
module tb_frame_scanout;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int N_PIX = W * H;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data = 24'h0;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          frame_done;

    int n_tests;
    int n_fail;
    int cyc;
    bit mon_en;
    int exp_idx;
    int n_xfer;
    int n_reads;
    int n_done;
    int done_cyc;
    int first_xfer_cyc;
    int last_xfer_cyc;
    bit prev_stall;

    frame_scanout #(
        .SCR_W (W),
        .SCR_H (H),
        .PIX_W (24),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pixel store model: data for the strobed address appears one cycle later;
    // non-read cycles return a marker value that must never reach the stream.
    always @(posedge clk) begin
        rd_data <= rd_en ? (24'h100000 + {20'd0, rd_addr}) : 24'hBAD000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        exp_idx        = 0;
        n_xfer         = 0;
        n_reads        = 0;
        n_done         = 0;
        done_cyc       = -10;
        first_xfer_cyc = -1;
        last_xfer_cyc  = -1;
        prev_stall     = 1'b0;
    endtask

    // One clock cycle: observe at the falling edge, then return 1 time unit
    // after the next rising edge so the caller can drive new inputs.
    task automatic tick();
        int occ;
        @(negedge clk);
        if (mon_en) begin
            occ = n_reads - n_xfer;
            check("occ_le_2", 32'(occ <= 2), 32'd1);
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), n_reads);
                n_reads++;
            end
            if (prev_stall) check("hold_valid", 32'(pix_valid), 32'd1);
            if (pix_valid) begin
                if (exp_idx >= N_PIX) begin
                    check("pixel_count", exp_idx, N_PIX - 1);
                end else begin
                    check("pix_data", 32'(pix_data), 32'h100000 + exp_idx);
                    check("pix_sof", 32'(pix_sof), 32'(exp_idx == 0));
                    check("pix_eol", 32'(pix_eol), 32'((exp_idx % W) == W - 1));
                    check("pix_eof", 32'(pix_eof), 32'(exp_idx == N_PIX - 1));
                end
                if (pix_ready) begin
                    if (n_xfer == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    n_xfer++;
                    exp_idx++;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd1);
            end
            if (n_done > 0 && cyc == done_cyc + 1) check("busy_fall", 32'(busy), 32'd0);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},      32'(rd_en),      32'd0);
        check({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
        check({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
        check({tag, "_pix_data"},   32'(pix_data),   32'd0);
        check({tag, "_pix_sof"},    32'(pix_sof),    32'd0);
        check({tag, "_pix_eol"},    32'(pix_eol),    32'd0);
        check({tag, "_pix_eof"},    32'(pix_eof),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // mode 0: ready held 1, mode 1: random ready, mode 2: ready 0 for 10 cycles.
    // extra pulses frame_start during RUN and during DONE.
    task automatic run_frame(input int mode, input bit extra);
        int n0;
        int g;
        clear_mon();
        mon_en = 1'b1;
        pix_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'(($urandom_range(0, 1))) : 1'b0);
        frame_start = 1'b1;
        n0 = cyc;
        tick();
        frame_start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        g = 0;
        while (!(n_done > 0 && cyc > done_cyc + 1) && g < 400) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = (cyc > n0 + 10);
            endcase
            if (mode == 2 && cyc == n0 + 11) check("stall_reads", n_reads, 32'd2);
            frame_start = extra && (cyc == n0 + 5 || cyc == n0 + 15);
            tick();
            g++;
        end
        frame_start = 1'b0;
        check("frame_timeout", 32'(g < 400), 32'd1);
        repeat (4) tick();
        check("xfer_count", n_xfer, N_PIX);
        check("read_count", n_reads, N_PIX);
        check("done_count", n_done, 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        if (mode == 0) begin
            check("first_xfer_cyc", first_xfer_cyc, n0 + 3);
            check("last_xfer_cyc", last_xfer_cyc, n0 + 2 + N_PIX);
            check("done_cyc", done_cyc, n0 + 3 + N_PIX);
        end
    endtask

    initial begin
        int g;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        mon_en      = 1'b0;
        reset       = 1'b0;
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        clear_mon();

        #1;
        check_outputs_zero("reset");
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Free-running frame with exact latency checks.
        run_frame(0, 1'b0);

        // Random back-pressure.
        repeat (4) run_frame(1, 1'b0);

        // Long initial stall: only two reads may issue.
        run_frame(2, 1'b0);

        // Ignored frame_start in RUN and DONE, then an identical second frame.
        run_frame(0, 1'b1);
        run_frame(0, 1'b0);

        // Reset after pixel 5 has been accepted.
        clear_mon();
        mon_en      = 1'b1;
        pix_ready   = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        g = 0;
        while (n_xfer < 6 && g < 50) begin
            tick();
            g++;
        end
        check("reset_wait", n_xfer, 32'd6);
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        mon_en = 1'b0;
        tick();
        reset = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        repeat (4) begin
            tick();
            check("stale_valid", 32'(pix_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        run_frame(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
